// File: rtl/ship_pkg.sv
`default_nettype none
// ============================================================================
// ship_pkg : shared types and constants for the ship weapon controller
// Revision : 1.0
// ============================================================================
package ship_pkg;

  localparam int MAX_SLOTS = 15;
  localparam int CNT_W     = 8;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SELECT   = 2'd1;
  localparam logic [1:0] ST_LAUNCH   = 2'd2;
  localparam logic [1:0] ST_COOLDOWN = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    SELECT   = ST_SELECT,
    LAUNCH   = ST_LAUNCH,
    COOLDOWN = ST_COOLDOWN
  } state_t;

  function automatic logic [3:0] popcount(input logic [MAX_SLOTS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < MAX_SLOTS; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ship_slot_picker.sv
`default_nettype none
// ============================================================================
// ship_slot_picker : lowest-index free slot allowed by the unlock level
// Revision : 1.0
// ============================================================================
module ship_slot_picker
  import ship_pkg::*;
#(
  parameter int SLOTS        = 4,
  parameter int LOCKED_SLOTS = 2
) (
  input  logic [SLOTS-1:0] busy,
  input  logic             unlocked,
  output logic [SLOTS-1:0] sel,
  output logic             any_free
);

  logic [SLOTS-1:0] enable_mask;
  logic [SLOTS-1:0] eligible;
  logic             found;

  generate
    for (genvar i = 0; i < SLOTS; i++) begin : g_mask
      assign enable_mask[i] = unlocked | (i < LOCKED_SLOTS);
    end
  endgenerate

  assign eligible = ~busy & enable_mask;
  assign any_free = |eligible;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      if (eligible[i] && !found) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ship_fire_ctl.sv
`default_nettype none
// ============================================================================
// ship_fire_ctl : fire-button to missile-slot launch sequencer with cooldown
// Revision : 1.0
// ============================================================================
module ship_fire_ctl
  import ship_pkg::*;
#(
  parameter int SLOTS           = 4,
  parameter int LOCKED_SLOTS    = 2,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             fire,
  input  logic             frame_tick,
  input  logic             unlocked,
  input  logic [SLOTS-1:0] slot_done,
  output logic [SLOTS-1:0] launch,
  output logic [SLOTS-1:0] slot_busy,
  output logic [3:0]       active_count,
  output logic             cooldown
);

  state_t           state;
  logic             fire_prev;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [SLOTS-1:0] pick;
  logic             any_free;

  assign press = fire & ~fire_prev;

  ship_slot_picker #(
    .SLOTS        (SLOTS),
    .LOCKED_SLOTS (LOCKED_SLOTS)
  ) u_picker (
    .busy     (slot_busy),
    .unlocked (unlocked),
    .sel      (pick),
    .any_free (any_free)
  );

  // launch doubles as the registered selection; it is only nonzero in LAUNCH
  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      fire_prev    <= 1'b1;
      launch       <= '0;
      slot_busy    <= '0;
      active_count <= '0;
      cooldown     <= 1'b0;
      cnt          <= '0;
    end else begin
      fire_prev    <= fire;
      launch       <= '0;
      slot_busy    <= (slot_busy & ~slot_done) | launch;
      active_count <= popcount(MAX_SLOTS'(slot_busy));
      case (state)
        IDLE: begin
          if (press) state <= SELECT;
        end
        SELECT: begin
          if (any_free) begin
            launch <= pick;
            state  <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          cnt      <= CNT_W'(COOLDOWN_FRAMES);
          cooldown <= 1'b1;
          state    <= COOLDOWN;
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt == CNT_W'(1)) begin
              cnt      <= '0;
              cooldown <= 1'b0;
              state    <= IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ship_fire_ctl.sv
`default_nettype none
// ============================================================================
// tb_ship_fire_ctl : directed self-checking bench for ship_fire_ctl
// Revision : 1.0
// ============================================================================
module tb_ship_fire_ctl;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       fire = 1'b0;
  logic       frame_tick = 1'b0;
  logic       unlocked = 1'b0;
  logic [3:0] slot_done = '0;
  logic [3:0] launch;
  logic [3:0] slot_busy;
  logic [3:0] active_count;
  logic       cooldown;

  int n_checks = 0;
  int n_fail   = 0;

  ship_fire_ctl #(
    .SLOTS           (4),
    .LOCKED_SLOTS    (2),
    .COOLDOWN_FRAMES (8)
  ) dut (
    .pclk         (pclk),
    .rst          (rst),
    .fire         (fire),
    .frame_tick   (frame_tick),
    .unlocked     (unlocked),
    .slot_done    (slot_done),
    .launch       (launch),
    .slot_busy    (slot_busy),
    .active_count (active_count),
    .cooldown     (cooldown)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; fire = 1'b0; frame_tick = 1'b0; slot_done = '0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Press in the current cycle; returns in the LAUNCH cycle (press + 2).
  task automatic press_to_launch();
    fire = 1'b1;
    tick();
    fire = 1'b0;
    tick();
  endtask

  task automatic run_cooldown();
    for (int i = 0; i < 8; i++) begin
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fire = 1'b1;
    tick(); tick();
    n_checks++;
    if (launch !== 4'b0 || slot_busy !== 4'b0 || active_count !== 4'd0 || cooldown !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: launch=%b busy=%b cnt=%0d cd=%b, want all 0", launch, slot_busy, active_count, cooldown);
    end
    rst = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (launch !== 4'b0 || cooldown !== 1'b0) begin
      n_fail++;
      $display("FAIL held_fire_no_launch: launch=%b cd=%b, want 0000 0", launch, cooldown);
    end
    fire = 1'b0;
    tick();
    fire = 1'b1;
    tick();
    n_checks++;
    if (launch !== 4'b0) begin
      n_fail++;
      $display("FAIL launch_early: launch=%b, want 0000", launch);
    end
    fire = 1'b0;
    tick();
    n_checks++;
    if (launch !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_launch: launch=%b, want 0001", launch);
    end
    tick();
    n_checks++;
    if (launch !== 4'b0 || slot_busy !== 4'b0001 || cooldown !== 1'b1) begin
      n_fail++;
      $display("FAIL after_launch: launch=%b busy=%b cd=%b, want 0000 0001 1", launch, slot_busy, cooldown);
    end
    tick();
    n_checks++;
    if (active_count !== 4'd1) begin
      n_fail++;
      $display("FAIL count_one: active_count=%0d, want 1", active_count);
    end
  endtask

  task automatic test_locked();
    do_reset();
    unlocked = 1'b0;
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0001) begin
      n_fail++;
      $display("FAIL locked_l0: launch=%b, want 0001", launch);
    end
    tick(); run_cooldown();
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0010) begin
      n_fail++;
      $display("FAIL locked_l1: launch=%b, want 0010", launch);
    end
    tick(); run_cooldown();
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0000 || cooldown !== 1'b0) begin
      n_fail++;
      $display("FAIL locked_drop: launch=%b cd=%b, want 0000 0", launch, cooldown);
    end
    tick();
    n_checks++;
    if (cooldown !== 1'b0 || slot_busy !== 4'b0011 || active_count !== 4'd2) begin
      n_fail++;
      $display("FAIL locked_after_drop: cd=%b busy=%b cnt=%0d, want 0 0011 2", cooldown, slot_busy, active_count);
    end
  endtask

  task automatic test_unlocked();
    logic [3:0] exp_l [3];
    exp_l[0] = 4'b0001; exp_l[1] = 4'b0010; exp_l[2] = 4'b0100;
    do_reset();
    unlocked = 1'b1;
    for (int i = 0; i < 3; i++) begin
      press_to_launch();
      n_checks++;
      if (launch !== exp_l[i]) begin
        n_fail++;
        $display("FAIL unlocked_l%0d: launch=%b, want %b", i, launch, exp_l[i]);
      end
      tick(); run_cooldown();
    end
    slot_done = 4'b0010;
    tick();
    slot_done = 4'b0000;
    n_checks++;
    if (slot_busy !== 4'b0101) begin
      n_fail++;
      $display("FAIL done_clears: busy=%b, want 0101", slot_busy);
    end
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0010) begin
      n_fail++;
      $display("FAIL reuse_slot1: launch=%b, want 0010", launch);
    end
    tick(); tick();
    n_checks++;
    if (active_count !== 4'd3) begin
      n_fail++;
      $display("FAIL unlocked_count: active_count=%0d, want 3", active_count);
    end
  endtask

  task automatic test_cooldown_discard();
    do_reset();
    unlocked = 1'b1;
    press_to_launch();
    frame_tick = 1'b1;  // tick in LAUNCH cycle must not be counted
    tick();
    frame_tick = 1'b0;
    for (int i = 0; i < 7; i++) begin
      frame_tick = 1'b1; fire = 1'b1;
      tick();
      frame_tick = 1'b0; fire = 1'b0;
      tick();
      n_checks++;
      if (launch !== 4'b0) begin
        n_fail++;
        $display("FAIL cd_press_%0d: launch=%b, want 0000", i, launch);
      end
    end
    n_checks++;
    if (cooldown !== 1'b1) begin
      n_fail++;
      $display("FAIL cd_after7: cooldown=%b, want 1", cooldown);
    end
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    n_checks++;
    if (cooldown !== 1'b0) begin
      n_fail++;
      $display("FAIL cd_after8: cooldown=%b, want 0", cooldown);
    end
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0010) begin
      n_fail++;
      $display("FAIL cd_exit_press: launch=%b, want 0010", launch);
    end
  endtask

  task automatic test_unlock_drop();
    do_reset();
    unlocked = 1'b1;
    for (int i = 0; i < 4; i++) begin
      press_to_launch();
      tick(); run_cooldown();
    end
    slot_done = 4'b0011;
    tick();
    slot_done = 4'b0000;
    unlocked = 1'b0;
    tick(); tick();
    n_checks++;
    if (slot_busy !== 4'b1100 || active_count !== 4'd2) begin
      n_fail++;
      $display("FAIL drop_keeps_busy: busy=%b cnt=%0d, want 1100 2", slot_busy, active_count);
    end
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_sel0: launch=%b, want 0001", launch);
    end
    tick();
    slot_done = 4'b0100;
    tick();
    slot_done = 4'b1000;
    tick();
    slot_done = 4'b0000;
    n_checks++;
    if (slot_busy !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_done: busy=%b, want 0001", slot_busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    unlocked = 1'b1;
    press_to_launch();
    tick();
    n_checks++;
    if (cooldown !== 1'b1 || slot_busy !== 4'b0001) begin
      n_fail++;
      $display("FAIL pre_rst: cd=%b busy=%b, want 1 0001", cooldown, slot_busy);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (launch !== 4'b0 || slot_busy !== 4'b0 || active_count !== 4'd0 || cooldown !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst: launch=%b busy=%b cnt=%0d cd=%b, want all 0", launch, slot_busy, active_count, cooldown);
    end
    tick();
    press_to_launch();
    n_checks++;
    if (launch !== 4'b0001) begin
      n_fail++;
      $display("FAIL post_rst_idle: launch=%b, want 0001", launch);
    end
  endtask

  initial begin
    test_reset();
    test_locked();
    test_unlocked();
    test_cooldown_discard();
    test_unlock_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
